// File: rtl/bus_controller.sv
// rtl/bus_controller.sv - instruction sequencer driving register enables and bus driver selects
module bus_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [22:0] instr,
    output logic [22:0] code,
    output logic [19:0] r_en_OH,
    output logic [19:0] tri_controller_OH,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    state_t      state_q, state_d;
    logic [22:0] code_q, code_d;

    logic [2:0]  op;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic        is_alu;
    logic [19:0] rx_oh;
    logic [19:0] ry_oh;

    localparam logic [19:0] G_OH   = 20'd1 << 9;
    localparam logic [19:0] A_OH   = 20'd1 << 10;
    localparam logic [19:0] IMM_OH = 20'd1 << 10;

    assign op     = code_q[22:20];
    assign rx     = code_q[19:17];
    assign is_alu = code_q[16];
    assign ry     = code_q[2:0];
    assign rx_oh  = 20'd1 << rx;
    assign ry_oh  = 20'd1 << ry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // Outputs depend only on state and latched code, so one-hotness holds by construction.
    always_comb begin
        state_d           = state_q;
        code_d            = code_q;
        r_en_OH           = '0;
        tri_controller_OH = '0;
        done              = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    code_d  = instr;
                    state_d = T1;
                end
            end
            T1: begin
                if (is_alu) begin
                    tri_controller_OH = rx_oh;
                    r_en_OH           = A_OH;
                    state_d           = T2;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                    if (op == 3'b000) begin
                        tri_controller_OH = ry_oh;
                        r_en_OH           = rx_oh;
                    end else if (op == 3'b001) begin
                        tri_controller_OH = IMM_OH;
                        r_en_OH           = rx_oh;
                    end
                end
            end
            T2: begin
                tri_controller_OH = ry_oh;
                r_en_OH           = G_OH;
                state_d           = T3;
            end
            T3: begin
                tri_controller_OH = G_OH;
                r_en_OH           = rx_oh;
                done              = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign code = code_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_bus_controller.sv
// tb/tb_bus_controller.sv - directed and random checks for bus_controller
module tb_bus_controller;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [22:0] instr;
    logic [22:0] code;
    logic [19:0] r_en_OH;
    logic [19:0] tri_controller_OH;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_err;

    bus_controller dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .run               (run),
        .instr             (instr),
        .code              (code),
        .r_en_OH           (r_en_OH),
        .tri_controller_OH (tri_controller_OH),
        .busy              (busy),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected T1 outputs: {tri, r_en}
    function automatic logic [39:0] t1_exp(input logic [22:0] w);
        logic [19:0] t, e;
        t = '0;
        e = '0;
        if (w[16]) begin
            t = 20'd1 << w[19:17];
            e = 20'd1 << 10;
        end else if (w[22:20] == 3'b000) begin
            t = 20'd1 << w[2:0];
            e = 20'd1 << w[19:17];
        end else if (w[22:20] == 3'b001) begin
            t = 20'd1 << 10;
            e = 20'd1 << w[19:17];
        end
        return {t, e};
    endfunction

    initial begin
        logic [39:0] ex;
        logic [22:0] w;
        int          n;
        int          dn;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        run   = 1'b0;
        instr = '0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_tri",  32'(tri_controller_OH), 32'd0);
        chk("rst_ren",  32'(r_en_OH), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        #20 rst_n = 1'b1;
        tick();

        // mvi R3, 16'hBEEF
        run = 1'b1; instr = 23'h16BEEF;
        tick();
        run = 1'b0; instr = '0;
        chk("mvi_tri",  32'(tri_controller_OH), 32'h400);
        chk("mvi_ren",  32'(r_en_OH), 32'h8);
        chk("mvi_done", 32'(done), 32'd1);
        chk("mvi_imm",  32'(code[15:0]), 32'hBEEF);
        tick();
        chk("mvi_busy_end", 32'(busy), 32'd0);
        chk("mvi_code_hold", 32'(code), 32'h16BEEF);

        // mv R5 <- R2
        run = 1'b1; instr = 23'h0A0002;
        tick();
        run = 1'b0;
        chk("mv_tri",  32'(tri_controller_OH), 32'h4);
        chk("mv_ren",  32'(r_en_OH), 32'h20);
        chk("mv_done", 32'(done), 32'd1);
        tick();
        chk("mv_busy_end", 32'(busy), 32'd0);

        // reserved move-class op 011
        run = 1'b1; instr = 23'h340005;
        tick();
        run = 1'b0;
        chk("nop_tri",  32'(tri_controller_OH), 32'h0);
        chk("nop_ren",  32'(r_en_OH), 32'h0);
        chk("nop_done", 32'(done), 32'd1);
        tick();

        // ALU op 010 on R1, R6, with a run pulse during T2
        run = 1'b1; instr = 23'h230006;
        tick();
        run = 1'b0; instr = '0;
        dn = 0;
        chk("alu_t1_tri", 32'(tri_controller_OH), 32'h2);
        chk("alu_t1_ren", 32'(r_en_OH), 32'h400);
        chk("alu_t1_done", 32'(done), 32'd0);
        tick();
        chk("alu_t2_tri", 32'(tri_controller_OH), 32'h40);
        chk("alu_t2_ren", 32'(r_en_OH), 32'h200);
        chk("alu_t2_op",  32'(code[22:20]), 32'd2);
        run = 1'b1; instr = 23'h0A0002;
        tick();
        run = 1'b0;
        dn += int'(done);
        chk("alu_t3_tri", 32'(tri_controller_OH), 32'h200);
        chk("alu_t3_ren", 32'(r_en_OH), 32'h2);
        chk("alu_t3_code", 32'(code), 32'h230006);
        tick();
        dn += int'(done);
        chk("alu_idle_busy", 32'(busy), 32'd0);
        tick();
        dn += int'(done);
        chk("alu_done_count", 32'(dn), 32'd1);
        chk("alu_ignored_run", 32'(busy), 32'd0);

        // asynchronous reset in the middle of T2
        run = 1'b1; instr = 23'h230006;
        tick();
        run = 1'b0;
        tick();
        chk("pre_rst_t2_ren", 32'(r_en_OH), 32'h200);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tri",  32'(tri_controller_OH), 32'h0);
        chk("arst_ren",  32'(r_en_OH), 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_code", 32'(code), 32'h0);

        // back-to-back acceptance with run held high
        run = 1'b1; instr = 23'h16BEEF;
        tick();
        chk("b2b_t1", 32'(busy), 32'd1);
        tick();
        chk("b2b_idle", 32'(busy), 32'd0);
        tick();
        chk("b2b_t1_again", 32'(busy), 32'd1);
        tick();

        // random stream with run held high
        for (int k = 0; k < 300; k++) begin
            w = 23'($urandom);
            instr = w;
            run = 1'b1;
            tick();
            ex = t1_exp(w);
            chk("rnd_t1_tri", 32'(tri_controller_OH), 32'(ex[39:20]));
            chk("rnd_t1_ren", 32'(r_en_OH), 32'(ex[19:0]));
            n = 0;
            dn = 0;
            while (busy && n < 8) begin
                chk("rnd_tri_onehot", 32'($countones(tri_controller_OH) <= 1), 32'd1);
                chk("rnd_ren_onehot", 32'($countones(r_en_OH) <= 1), 32'd1);
                dn += int'(done);
                n++;
                tick();
            end
            chk("rnd_latency", 32'(n), w[16] ? 32'd3 : 32'd1);
            chk("rnd_done_cnt", 32'(dn), 32'd1);
        end
        run = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
